// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell.
// Operands are captured on an accepted start, then fed LSB first through the
// cell, one bit per clock, with the cell carry held in a one-bit register.
// The result is published on the last bit edge and held until the next one.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value on the edge that processes the MSB.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_s_next;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  // One-bit full-adder cell on the current operand LSBs and the carry register.
  assign w_fa_sum   = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_fa_carry = (r_a_sh[0] & r_b_sh[0]) | (r_c & (r_a_sh[0] ^ r_b_sh[0]));

  // Sum bits enter at the MSB and move right, so after WIDTH shifts the
  // first (LSB) sum bit lands in bit 0.
  generate
    if (WIDTH == 1) begin : g_s_w1
      assign w_s_next = w_fa_sum;
    end else begin : g_s_wn
      assign w_s_next = {w_fa_sum, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the busy/done status outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, serial shifting, carry register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift registers are cleared on reset like any other flop,
    // so an abandoned operation leaves no stale bits behind.
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_s_sh <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_c    <= cin;
      r_cnt  <= '0;
    end else if (w_run) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_s_sh <= w_s_next;
      r_c    <= w_fa_carry;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Result registers: updated only on the final bit edge, held otherwise.
  // r_c is the carry into the MSB on that edge, giving signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_run && w_last) begin
      r_sum       <= w_s_next;
      r_carry_out <= w_fa_carry;
      r_overflow  <= r_c ^ w_fa_carry;
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8.
// Expected results are computed from a+b+cin when an accepted start is
// driven, queued, and popped when the DUT raises done.
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 40;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Reference: full-width addition; signed overflow when both operands share
  // a sign and the result sign differs.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    exp_t        e;
    logic [WIDTH:0] tot;
    tot   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    e.sum = tot[WIDTH-1:0];
    e.co  = tot[WIDTH];
    e.ov  = (x[WIDTH-1] == y[WIDTH-1]) && (tot[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // Called at a negedge. Waits for IDLE, presents one start pulse and queues
  // the expected result. Returns at the negedge after the accepting edge.
  task automatic do_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic c);
    int guard;
    guard = 0;
    while ((busy === 1'b1 || done === 1'b1) && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    a     = x;
    b     = y;
    cin   = c;
    sb.push_back(model(x, y, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge. Waits (bounded) for done,
  // reporting latency in cycles and the number of busy samples seen.
  task automatic wait_done(output int lat, output int bcnt, output bit to);
    lat  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bcnt++;
    end
    to = (done !== 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, carry_out, overflow, sum} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_held: {busy,done,co,ov,sum}=%h expected 000",
               {busy, done, carry_out, overflow, sum});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, carry_out, overflow, sum} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: {busy,done,co,ov,sum}=%h expected 000",
                 i, {busy, done, carry_out, overflow, sum});
      end
    end
  endtask

  task automatic test_basic;
    exp_t e;
    int   lat;
    int   bcnt;
    bit   to;
    do_start(8'h0F, 8'h01, 1'b0);
    wait_done(lat, bcnt, to);
    n_checks++;
    if (to !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_timeout: done not seen within %0d cycles", MAX_WAIT);
    end
    n_checks++;
    if (lat !== WIDTH) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d edges expected %0d", lat, WIDTH);
    end
    n_checks++;
    if (bcnt !== WIDTH) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: busy for %0d cycles expected %0d", bcnt, WIDTH);
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL basic_scoreboard: got done with empty queue expected entry");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({carry_out, overflow, sum} !== {e.co, e.ov, e.sum}) begin
        n_fail++;
        $display("FAIL basic_result: {co,ov,sum}=%h expected %h",
                 {carry_out, overflow, sum}, {e.co, e.ov, e.sum});
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || sum !== 8'h10) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: done=%b sum=%h expected done=0 sum=10", done, sum);
    end
  endtask

  task automatic test_corners;
    logic [WIDTH-1:0] ta[3];
    logic [WIDTH-1:0] tb_[3];
    logic             tc[3];
    exp_t e;
    int   lat;
    int   bcnt;
    bit   to;
    ta[0] = 8'hFF; tb_[0] = 8'h01; tc[0] = 1'b0;
    ta[1] = 8'h7F; tb_[1] = 8'h01; tc[1] = 1'b0;
    ta[2] = 8'hFF; tb_[2] = 8'hFF; tc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_start(ta[i], tb_[i], tc[i]);
      wait_done(lat, bcnt, to);
      n_checks++;
      if (to !== 1'b0) begin
        n_fail++;
        $display("FAIL corner_timeout[%0d]: done not seen within %0d cycles", i, MAX_WAIT);
      end
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL corner_scoreboard[%0d]: got done with empty queue", i);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if ({carry_out, overflow, sum} !== {e.co, e.ov, e.sum}) begin
          n_fail++;
          $display("FAIL corner_result[%0d]: {co,ov,sum}=%h expected %h",
                   i, {carry_out, overflow, sum}, {e.co, e.ov, e.sum});
        end
      end
      @(negedge clk);
    end
  endtask

  // start held high: the second accept must land exactly WIDTH+2 edges after
  // the first and capture the operand value changed during the first RUN.
  task automatic test_ignored_start;
    exp_t e;
    bit   hold_ok;
    int   guard;
    guard = 0;
    while ((busy === 1'b1 || done === 1'b1) && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    start   = 1'b1;
    a       = 8'h01;
    b       = 8'h01;
    cin     = 1'b0;
    sb.push_back(model(8'h01, 8'h01, 1'b0));
    hold_ok = 1'b1;
    for (int t = 0; t <= 18; t++) begin
      @(negedge clk);
      if (t == 2) begin
        a = 8'h20;
        sb.push_back(model(8'h20, 8'h01, 1'b0));
      end
      if (t == 8 || t == 18) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL ignored_done_at_%0d: done=%b expected 1", t, done);
        end
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ignored_scoreboard_%0d: empty queue", t);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if ({carry_out, overflow, sum} !== {e.co, e.ov, e.sum}) begin
            n_fail++;
            $display("FAIL ignored_result_%0d: {co,ov,sum}=%h expected %h",
                     t, {carry_out, overflow, sum}, {e.co, e.ov, e.sum});
          end
        end
      end
      if (t == 9) begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL ignored_idle_gap: busy=%b done=%b expected 0 0", busy, done);
        end
      end
      if (t == 10) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL ignored_reaccept: busy=%b expected 1 after tenth edge", busy);
        end
      end
      if (t >= 9 && t <= 17 && sum !== 8'h02) hold_ok = 1'b0;
      if (t == 18) start = 1'b0;
    end
    n_checks++;
    if (hold_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_sum_hold: sum changed before second done (now %h) expected 02", sum);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   seen_done;
    int   lat;
    int   bcnt;
    bit   to;
    do_start(8'h55, 8'hAA, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if ({busy, done, carry_out, overflow, sum} !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_clear: {busy,done,co,ov,sum}=%h expected 000",
               {busy, done, carry_out, overflow, sum});
    end
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: activity seen after reset expected none");
    end
    do_start(8'h01, 8'h02, 1'b0);
    wait_done(lat, bcnt, to);
    n_checks++;
    if (to !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_timeout: done not seen within %0d cycles", MAX_WAIT);
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL midreset_scoreboard: empty queue");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({carry_out, overflow, sum} !== {e.co, e.ov, e.sum}) begin
        n_fail++;
        $display("FAIL midreset_result: {co,ov,sum}=%h expected %h",
                 {carry_out, overflow, sum}, {e.co, e.ov, e.sum});
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_single_done: done=%b expected 0", done);
    end
  endtask

  task automatic test_random;
    exp_t             e;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
    int               lat;
    int               bcnt;
    bit               to;
    for (int i = 0; i < 500; i++) begin
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      c = 1'($urandom_range(1, 0));
      do_start(x, y, c);
      wait_done(lat, bcnt, to);
      n_checks++;
      if (to !== 1'b0 || lat !== WIDTH) begin
        n_fail++;
        $display("FAIL rand_latency[%0d]: done after %0d edges expected %0d", i, lat, WIDTH);
      end
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_scoreboard[%0d]: empty queue", i);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if ({carry_out, overflow, sum} !== {e.co, e.ov, e.sum}) begin
          n_fail++;
          $display("FAIL rand_result[%0d]: %h+%h+%b gave {co,ov,sum}=%h expected %h",
                   i, x, y, c, {carry_out, overflow, sum}, {e.co, e.ov, e.sum});
        end
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_single_done[%0d]: done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_leftover: %0d queued results expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder that wraps the one-bit full-adder cell with a carry register, operand shift registers and a control FSM. It adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It sits directly upstream of the full-adder cell, sequencing operand bits into it and collecting its sum and carry outputs. It gives the datapath a multi-bit add with one full-adder instance instead of a WIDTH-cell ripple chain.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
CNT_W, $clog2(WIDTH+1), width of internal bit counter

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while bits are being processed (RUN)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  registered result, held until the next done
carry_out  output  1  final carry out of MSB, held with sum
overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB), held with sum

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0, any time including mid-RUN): state=IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0. Counter, shift registers and carry register are cleared. An operation in progress is abandoned and no done is produced.
- FSM states and transitions:
  - IDLE: if start=1 on edge E0, load a_sh<=a, b_sh<=b, c_reg<=cin, cnt<=0, go to RUN. Otherwise stay in IDLE.
  - RUN: each edge, the full-adder cell takes a_sh[0], b_sh[0] and c_reg. The sum bit shifts into the MSB of s_sh (right shift). c_reg<=cell carry. a_sh and b_sh shift right. cnt++.
    - On the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge): sum<=final s_sh, carry_out<=cell carry, overflow<=c_reg XOR cell carry (c_reg is the carry into the MSB). Go to DONE.
  - DONE: unconditionally go to IDLE on the next edge.
- busy=1 exactly in RUN (WIDTH cycles). done=1 exactly in DONE (1 cycle).
- Latency: start accepted at edge E0. busy is high after E0 through E_WIDTH. done is high for the single cycle after edge E_WIDTH, with sum, carry_out and overflow already valid in that cycle.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is accepted at the edge that leaves IDLE, i.e. edge E_(WIDTH+2).
- start while busy=1 or done=1 is ignored, with no queuing. Operands presented with an ignored start are not captured.
- a, b and cin only matter on the accepting edge; changes during RUN have no effect.
- sum, carry_out and overflow change only on the final RUN edge or on reset. They keep their value through IDLE and the next RUN.
- Arithmetic: {carry_out,sum} = a + b + cin, modulo 2^(WIDTH+1). No internal state wraps except cnt, which resets on every accepted start.
- WIDTH=1: RUN lasts one cycle, and overflow = cin XOR carry_out.

Test Plan:
- Reset then idle, WIDTH=8: rst_n low then high, start=0 for 20 cycles -> busy=0, done=0, sum=0x00, carry_out=0, overflow=0 throughout.
- Basic add: a=0x0F, b=0x01, cin=0, start pulse at E0 -> busy high for 8 cycles, done pulse in the cycle after E8, sum=0x10, carry_out=0, overflow=0.
- Carry and overflow corners:
  - 0xFF+0x01+0 -> sum=0x00, carry_out=1, overflow=0.
  - 0x7F+0x01+0 -> sum=0x80, carry_out=0, overflow=1.
  - 0xFF+0xFF+1 -> sum=0xFF, carry_out=1, overflow=0.
- Ignored start: start=1 held continuously with a=0x01, b=0x01; change a to 0x20 at E3 -> the first result is 0x02. The next start is accepted exactly at E10 and captures a=0x20, so the second result is 0x21. sum stays 0x02 until the second done.
- Reset mid-operation: start 0x55+0xAA, assert rst_n=0 at cycle 4 of RUN -> immediate busy=0, sum=0, no done ever. After release, start 0x01+0x02 -> sum=0x03, single done.
- Randomised sweep: 500 random a, b and cin triples -> each {carry_out,sum} equals a+b+cin, overflow matches the signed-overflow reference, and exactly one done per accepted start.
